// File: rtl/x_stream_driver.sv
// x_stream_driver
//   Drives a counting block under test: issues a one-cycle start strobe (S),
//   then len count-enable pulses (X) separated by gap idle cycles. Afterwards
//   it waits up to 8 cycles for the block's done flag (G) and registers a
//   verdict: G must have been seen exactly when len >= THRESH.
//
// Ports
//   clock   sole clock, all state changes on posedge
//   reset   asynchronous, active-low reset
//   go      run request, accepted only in IDLE
//   len     number of X pulses (0..31), captured on accept
//   gap     idle cycles between X pulses (0..3), captured on accept
//   G       done flag returned by the counting block
//   S       start strobe (START state)
//   X       count-enable stream (SEND state)
//   busy    run in progress (START/SEND/GAP/WAIT)
//   done    one-cycle end-of-run strobe (DONE state)
//   pass    run verdict, valid from done until the next accept
//   pcount  X pulses emitted in the current or last run
module x_stream_driver #(
  parameter int unsigned THRESH = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [4:0] len,
  input  logic [1:0] gap,
  input  logic       G,
  output logic       S,
  output logic       X,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] pcount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    SEND  = 3'd2,
    GAP   = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [5:0] THRESH_W = 6'(THRESH);

  state_t     state;
  logic [4:0] len_r;
  logic [1:0] gap_r;
  logic [1:0] gcnt;
  logic [2:0] wcnt;
  logic       g_seen;
  logic [4:0] pcount_inc;
  logic       len_ge;

  always_comb begin
    pcount_inc = pcount + 5'd1;
    len_ge     = ({1'b0, len_r} >= THRESH_W);
  end

  // Moore outputs decoded purely from the state register.
  assign S    = (state == START);
  assign X    = (state == SEND);
  assign done = (state == DONE);
  assign busy = (state == START) || (state == SEND) ||
                (state == GAP)   || (state == WAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      len_r  <= '0;
      gap_r  <= '0;
      gcnt   <= '0;
      wcnt   <= '0;
      g_seen <= 1'b0;
      pass   <= 1'b0;
      pcount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            len_r  <= len;
            gap_r  <= gap;
            pcount <= '0;
            g_seen <= 1'b0;
            pass   <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (G) g_seen <= 1'b1;
          wcnt  <= '0;
          state <= (len_r != 5'd0) ? SEND : WAIT;
        end
        SEND: begin
          if (G) g_seen <= 1'b1;
          if (pcount != len_r) pcount <= pcount_inc;
          if (pcount_inc == len_r) begin
            wcnt  <= '0;
            state <= WAIT;
          end else if (gap_r == 2'd0) begin
            state <= SEND;
          end else begin
            // Reload so GAP lasts exactly gap_r cycles (last cycle at gcnt==0).
            gcnt  <= gap_r - 2'd1;
            state <= GAP;
          end
        end
        GAP: begin
          if (G) g_seen <= 1'b1;
          if (gcnt == 2'd0) state <= SEND;
          else              gcnt  <= gcnt - 2'd1;
        end
        WAIT: begin
          if (G) g_seen <= 1'b1;
          if (G || (wcnt == 3'd7)) begin
            // Verdict includes this edge's G sample.
            pass  <= ((g_seen | G) == len_ge);
            state <= DONE;
          end else begin
            wcnt <= wcnt + 3'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_stream_driver.sv
// tb_x_stream_driver
//   Directed bench for x_stream_driver. Cycle n is the clock period that
//   follows edge n-1, where edge 0 samples go.
module tb_x_stream_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       go    = 1'b0;
  logic [4:0] len   = '0;
  logic [1:0] gap   = '0;
  logic       G     = 1'b0;
  logic       S, X, busy, done, pass;
  logic [4:0] pcount;

  int checks = 0;
  int errors = 0;

  x_stream_driver #(.THRESH(15)) dut (
    .clock  (clock),
    .reset  (reset),
    .go     (go),
    .len    (len),
    .gap    (gap),
    .G      (G),
    .S      (S),
    .X      (X),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .pcount (pcount)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One run: G high during cycle gcyc (0 = never), go pulsed in cycles gox1/gox2
  // (0 = never). Mid-run len/gap are scrambled to show they are ignored.
  task automatic run(input string name, input logic [4:0] l, input logic [1:0] gp,
                     input int gcyc, input int gox1, input int gox2, input int ncyc,
                     input int exp_xcnt, input int exp_xfirst, input int exp_xlast,
                     input int exp_done, input logic exp_pass);
    int s_cnt, s_first, x_cnt, x_first, x_last, d_cnt, d_cyc;
    logic pass1, busy_d;
    s_cnt = 0; s_first = 0; x_cnt = 0; x_first = 0; x_last = 0;
    d_cnt = 0; d_cyc = 0; pass1 = 1'b1; busy_d = 1'b1;
    len = l; gap = gp; go = 1'b1;
    tick();
    go = 1'b0; len = ~l; gap = ~gp;
    for (int c = 1; c <= ncyc; c++) begin
      G  = (c == gcyc);
      go = (c == gox1) || (c == gox2);
      if (c == 1) pass1 = pass;
      if (S) begin s_cnt++; if (s_first == 0) s_first = c; end
      if (X) begin x_cnt++; if (x_first == 0) x_first = c; x_last = c; end
      if (done) begin d_cnt++; d_cyc = c; busy_d = busy; end
      tick();
    end
    G = 1'b0; go = 1'b0;
    check({name, " s_cnt"},   s_cnt, 1);
    check({name, " s_first"}, s_first, 1);
    check({name, " x_cnt"},   x_cnt, exp_xcnt);
    check({name, " x_first"}, x_first, exp_xfirst);
    check({name, " x_last"},  x_last, exp_xlast);
    check({name, " d_cnt"},   d_cnt, 1);
    check({name, " d_cyc"},   d_cyc, exp_done);
    check({name, " busy@done"}, busy_d, 0);
    check({name, " pass@c1"}, pass1, 0);
    check({name, " pass"},    pass, exp_pass);
    check({name, " pcount"},  pcount, l);
    check({name, " idle busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_cnt;
    // Reset state
    #12;
    check("rst S", S, 0);
    check("rst X", X, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst pcount", pcount, 0);
    tick();
    reset = 1'b1;
    tick();

    // len=3 gap=0: X 2-4, WAIT 5-12, done 13, pass=1
    run("r1", 5'd3, 2'd0, 0, 0, 0, 16, 3, 2, 4, 13, 1'b1);
    // len=15 gap=0, no G: timeout, done 25, pass=0 (also clears prior pass)
    run("r3", 5'd15, 2'd0, 0, 0, 0, 28, 15, 2, 16, 25, 1'b0);
    // len=16 gap=1: X on 2,4..32; G in cycle 35 -> done 36, pass=1
    run("r2", 5'd16, 2'd1, 35, 0, 0, 40, 16, 2, 32, 36, 1'b1);
    // len=0: START then 8 WAIT cycles, done 10, pass=1, pcount=0
    run("r4", 5'd0, 2'd2, 0, 0, 0, 12, 0, 0, 0, 10, 1'b1);
    // go during SEND (cycle 3) and in DONE (cycle 13) are ignored
    run("r6", 5'd3, 2'd0, 0, 3, 13, 20, 3, 2, 4, 13, 1'b1);
    // len=3 gap=3: X on 2,6,10; WAIT 11-18; done 19; G in 4 (GAP) with len<15 -> pass=0
    run("r7", 5'd3, 2'd3, 4, 0, 0, 22, 3, 2, 10, 19, 1'b0);

    // Reset during the 5th X pulse of len=10
    len = 5'd10; gap = 2'd0; go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("r5 X before", X, 1);
    check("r5 pcount before", pcount, 4);
    #2 reset = 1'b0;
    #1;
    check("r5 X", X, 0);
    check("r5 busy", busy, 0);
    check("r5 pcount", pcount, 0);
    check("r5 done", done, 0);
    d_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) d_cnt++;
      tick();
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done) d_cnt++;
      tick();
    end
    check("r5 no done", d_cnt, 0);
    check("r5 idle busy", busy, 0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check("r5 restart S", S, 1);
    check("r5 restart busy", busy, 1);
    tick();
    check("r5 restart X", X, 1);
    for (int i = 0; i < 25; i++) tick();
    check("r5 final pcount", pcount, 10);
    check("r5 final busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
